// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: the active-low segment
// patterns (bit 0 = a .. bit 6 = g) and the blank value.
package seg_scan_driver_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg_scan_driver_hex_to_seg7.sv
// Combinational hex-to-seven-segment decoder, active-low outputs, b and d in
// lowercase. Shared with the counter stage's own segment output.
module hex_to_seg7
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: every path assigns seg_o (default first, full case) so no latch is inferred.
        seg_o = SEG_BLANK;
        unique case (value_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with registered outputs.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    scan_tk
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seg_scan_driver: NUM_DIGITS=%0d outside 2..8", NUM_DIGITS);
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("seg_scan_driver: REFRESH_DIV=%0d must be >= 2", REFRESH_DIV);
    end

    logic [CNT_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  scan_tk_q, scan_tk_d;
    logic                  tick;
    logic [3:0]            sel_val;
    logic [6:0]            sel_seg;
    logic [NUM_DIGITS-1:0] blank_mask;

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every more significant digit are zero.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run      = zero_run & (digits[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_run;
        end
    end
`else
    assign blank_mask = '0;
`endif

    // idx_q names the digit that will be lit at the next tick, so digit 0 comes first.
    assign sel_val = digits[4*int'(idx_q) +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .value_i (sel_val),
        .seg_o   (sel_seg)
    );

    always_comb begin
        tick      = (presc_q == CNT_W'(REFRESH_DIV - 1));
        presc_d   = tick ? '0 : presc_q + CNT_W'(1);
        idx_d     = idx_q;
        an_d      = an_q;
        seg_d     = seg_q;
        dp_d      = dp_q;
        scan_tk_d = tick;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            if (blank_mask[idx_q]) begin
                an_d  = '1;
                seg_d = SEG_BLANK;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(NUM_DIGITS'(1) << idx_q);
                seg_d = sel_seg;
                dp_d  = ~dp_in[idx_q];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q   <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            scan_tk_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            scan_tk_q <= scan_tk_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign scan_tk = scan_tk_q;

endmodule
